// File: rtl/ram_bus_master_if.sv
// Request/response handshake and SRAM control signals between the cache side, the master and the RAM.
// The tri-state data line is not part of this bundle; it stays a plain inout on ram_bus_master.
interface ram_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_last;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic        mem_bw;
  logic        mem_hold;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, mem_hold,
    output req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
           mem_addr, mem_ce_n, mem_oe_n, mem_we_n, mem_bw
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, mem_hold,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
           mem_addr, mem_ce_n, mem_oe_n, mem_we_n, mem_bw
  );
endinterface

// File: rtl/ram_bus_master.sv
// SRAM bus initiator: word read, word/byte write and line fill with hold-based wait states.
// Define HOLD_TIMEOUT_EN to abort reads whose hold outlasts TIMEOUT_CYCLES in one word.
module ram_bus_master #(
  parameter int LINE_WORDS        = 4,
  parameter int MIN_ACCESS_CYCLES = 1
`ifdef HOLD_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES  = 64
`endif
) (
  input  logic               clk,
  input  logic               reset,
  ram_bus_master_if.master   bus,
  inout  wire  [31:0]        mem_data
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int K_W   = $clog2(MIN_ACCESS_CYCLES + 1);
  localparam logic [31:0]      LINE_MASK = 32'(LINE_WORDS * 4 - 1);
  localparam logic [K_W-1:0]   K_MIN     = K_W'(MIN_ACCESS_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(LINE_WORDS - 1);
`ifdef HOLD_TIMEOUT_EN
  localparam int W_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W_W-1:0] W_MAX = W_W'(TIMEOUT_CYCLES);
`endif

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_STROBE, WR_REL} state_t;

  state_t           state, state_nxt;
  logic [K_W-1:0]   k, k_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             fill, fill_nxt;
  logic [31:0]      addr, addr_nxt;
  logic             ce_n, ce_n_nxt;
  logic             oe_n, oe_n_nxt;
  logic             we_n, we_n_nxt;
  logic             bw, bw_nxt;
  logic             drive, drive_nxt;
  logic [31:0]      wdata, wdata_nxt;
  logic             rsp_valid, rsp_valid_nxt;
  logic             rsp_last, rsp_last_nxt;
  logic [31:0]      rsp_rdata, rsp_rdata_nxt;
  logic             ready, ready_nxt;
`ifdef HOLD_TIMEOUT_EN
  logic [W_W-1:0]   wcnt, wcnt_nxt;
  logic             rsp_err, rsp_err_nxt;
`endif

  // Every output is a flop; this block only computes the values they take at the next edge.
  always_comb begin
    state_nxt     = state;
    k_nxt         = k;
    idx_nxt       = idx;
    fill_nxt      = fill;
    addr_nxt      = addr;
    ce_n_nxt      = ce_n;
    oe_n_nxt      = oe_n;
    we_n_nxt      = we_n;
    bw_nxt        = bw;
    drive_nxt     = drive;
    wdata_nxt     = wdata;
    rsp_valid_nxt = 1'b0;
    rsp_last_nxt  = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
`ifdef HOLD_TIMEOUT_EN
    wcnt_nxt      = wcnt;
    rsp_err_nxt   = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          k_nxt   = K_W'(1);
          idx_nxt = '0;
`ifdef HOLD_TIMEOUT_EN
          wcnt_nxt = W_W'(1);
`endif
          if (bus.req_op == 2'b00 || bus.req_op == 2'b11) begin
            state_nxt = RD;
            fill_nxt  = (bus.req_op == 2'b11);
            addr_nxt  = (bus.req_op == 2'b11) ? (bus.req_addr & ~LINE_MASK)
                                              : {bus.req_addr[31:2], 2'b00};
            ce_n_nxt  = 1'b0;
            oe_n_nxt  = 1'b0;
            we_n_nxt  = 1'b1;
            bw_nxt    = 1'b1;
          end else begin
            state_nxt = WR_SETUP;
            fill_nxt  = 1'b0;
            ce_n_nxt  = 1'b0;
            oe_n_nxt  = 1'b1;
            we_n_nxt  = 1'b1;
            drive_nxt = 1'b1;
            bw_nxt    = (bus.req_op == 2'b01);
            // Byte writes replicate the byte on every lane; the RAM picks the lane from addr[1:0].
            if (bus.req_op == 2'b01) begin
              addr_nxt  = {bus.req_addr[31:2], 2'b00};
              wdata_nxt = bus.req_wdata;
            end else begin
              addr_nxt  = bus.req_addr;
              wdata_nxt = {4{bus.req_wdata[7:0]}};
            end
          end
        end
      end

      RD: begin
        if (k >= K_MIN && !bus.mem_hold) begin
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = mem_data;
          k_nxt         = K_W'(1);
`ifdef HOLD_TIMEOUT_EN
          wcnt_nxt      = W_W'(1);
`endif
          if (!fill || idx == IDX_LAST) begin
            rsp_last_nxt = 1'b1;
            ce_n_nxt     = 1'b1;
            oe_n_nxt     = 1'b1;
            state_nxt    = IDLE;
          end else begin
            addr_nxt = addr + 32'd4;
            idx_nxt  = idx + 1'b1;
          end
        end
`ifdef HOLD_TIMEOUT_EN
        else if (bus.mem_hold && wcnt >= W_MAX) begin
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rsp_last_nxt  = 1'b1;
          rsp_rdata_nxt = '0;
          ce_n_nxt      = 1'b1;
          oe_n_nxt      = 1'b1;
          state_nxt     = IDLE;
        end
`endif
        else begin
          if (k < K_MIN) k_nxt = k + 1'b1;
`ifdef HOLD_TIMEOUT_EN
          if (wcnt < W_MAX) wcnt_nxt = wcnt + 1'b1;
`endif
        end
      end

      WR_SETUP: begin
        we_n_nxt  = 1'b0;
        state_nxt = WR_STROBE;
      end

      WR_STROBE: begin
        we_n_nxt      = 1'b1;
        ce_n_nxt      = 1'b1;
        rsp_valid_nxt = 1'b1;
        rsp_last_nxt  = 1'b1;
        state_nxt     = WR_REL;
      end

      WR_REL: begin
        drive_nxt = 1'b0;
        bw_nxt    = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        ce_n_nxt  = 1'b1;
        oe_n_nxt  = 1'b1;
        we_n_nxt  = 1'b1;
        drive_nxt = 1'b0;
      end
    endcase

    ready_nxt = (state_nxt == IDLE);
  end

  // State and output registers; reset parks the bus with all enables inactive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      idx       <= '0;
      fill      <= 1'b0;
      addr      <= '0;
      ce_n      <= 1'b1;
      oe_n      <= 1'b1;
      we_n      <= 1'b1;
      bw        <= 1'b1;
      drive     <= 1'b0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_rdata <= '0;
      ready     <= 1'b1;
`ifdef HOLD_TIMEOUT_EN
      wcnt      <= '0;
      rsp_err   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      idx       <= idx_nxt;
      fill      <= fill_nxt;
      addr      <= addr_nxt;
      ce_n      <= ce_n_nxt;
      oe_n      <= oe_n_nxt;
      we_n      <= we_n_nxt;
      bw        <= bw_nxt;
      drive     <= drive_nxt;
      wdata     <= wdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_last  <= rsp_last_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      ready     <= ready_nxt;
`ifdef HOLD_TIMEOUT_EN
      wcnt      <= wcnt_nxt;
      rsp_err   <= rsp_err_nxt;
`endif
    end
  end

  assign mem_data      = drive ? wdata : 32'hzzzz_zzzz;
  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_last  = rsp_last;
  assign bus.mem_addr  = addr;
  assign bus.mem_ce_n  = ce_n;
  assign bus.mem_oe_n  = oe_n;
  assign bus.mem_we_n  = we_n;
  assign bus.mem_bw    = bw;
`ifdef HOLD_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_bus_master.sv
// Randomized bench for ram_bus_master: an SRAM device model on the bus plus a word-array
// reference that predicts read data, byte merges and response timing from hold patterns.
module tb_ram_bus_master;

  localparam int LINE_WORDS = 4;
  localparam int MIN_ACC    = 1;
  localparam int TMO        = 8;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_bus_master_if bus();
  wire [31:0] mem_data;

  ram_bus_master #(
    .LINE_WORDS(LINE_WORDS),
    .MIN_ACCESS_CYCLES(MIN_ACC)
`ifdef HOLD_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .mem_data(mem_data)
  );

  // SRAM device: drives stale garbage while hold is high so any early capture is visible.
  logic [31:0] dev_mem [64];
  logic [31:0] dev_q;
  logic        dev_drive;
  logic        load_en;
  logic [5:0]  load_idx;
  logic [31:0] load_val;

  always_comb begin
    dev_drive = !bus.mem_ce_n && !bus.mem_oe_n;
    dev_q     = bus.mem_hold ? 32'hBAD0_BAD0 : dev_mem[bus.mem_addr[7:2]];
  end
  assign mem_data = dev_drive ? dev_q : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (load_en)
      dev_mem[load_idx] <= load_val;
    else if (!bus.mem_ce_n && !bus.mem_we_n) begin
      if (bus.mem_bw)
        dev_mem[bus.mem_addr[7:2]] <= mem_data;
      else
        dev_mem[bus.mem_addr[7:2]][{bus.mem_addr[1:0], 3'b000} +: 8] <= mem_data[{bus.mem_addr[1:0], 3'b000} +: 8];
    end
  end

  // Reference model: memory contents as the cache expects them, plus the last read data.
  logic [31:0] ref_mem [64];
  logic [31:0] model_rdata;
  int errCount   = 0;
  int checkCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return ref_mem[a[7:2]];
  endfunction

  task automatic refWrite(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w;
    int lane;
    w = ref_mem[a[7:2]];
    lane = int'(a[1:0]);
    if (op == 2'b01) w = d;
    else w[lane*8 +: 8] = d[7:0];
    ref_mem[a[7:2]] = w;
  endtask

  task automatic waitReady();
    int wi;
    @(negedge clk);
    for (wi = 0; wi < 50 && !bus.req_ready; wi++) @(negedge clk);
    checkOutput("ready_before_req", bus.req_ready, 1'b1);
  endtask

  // One request; holdCycles >= 0 fixes the hold length per word, -1 picks 0..3 per word.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata, input int holdCycles);
    int expC[$];
    logic [31:0] expD[$];
    logic [31:0] expA[$];
    logic expL[$];
    bit sched[$];
    logic [31:0] base;
    int nWords, c, readyAt, seen, weLow, overlap, rdEnBad, h, len, aIdx, vIdx;
    bit isRead;
    isRead = (op == 2'b00 || op == 2'b11);
    nWords = 1; c = 0; seen = 0; weLow = 0; overlap = 0; rdEnBad = 0; aIdx = 0; vIdx = 0;
    if (isRead) begin
      base = (op == 2'b11) ? (addr & ~32'(LINE_WORDS*4 - 1)) : (addr & ~32'h3);
      if (op == 2'b11) nWords = LINE_WORDS;
      for (int i = 0; i < nWords; i++) begin
        h = (holdCycles >= 0) ? holdCycles : int'($urandom_range(0, 3));
        len = (h + 1 > MIN_ACC) ? h + 1 : MIN_ACC;
        for (int j = 0; j < h; j++) sched.push_back(1'b1);
        for (int j = h; j < len; j++) sched.push_back(1'b0);
        c += len;
        expC.push_back(c);
        expA.push_back(base + 32'(4*i));
        expD.push_back(refRead(base + 32'(4*i)));
        expL.push_back(i == nWords - 1);
      end
      readyAt = c + 1;
    end else begin
      expC.push_back(2);
      expA.push_back(op == 2'b01 ? (addr & ~32'h3) : addr);
      expD.push_back(model_rdata);
      expL.push_back(1'b1);
      readyAt = 4;
    end

    waitReady();
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.mem_hold  = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;

    for (int n = 1; n <= readyAt; n++) begin
      @(negedge clk);
      if (!bus.mem_oe_n && !bus.mem_we_n) overlap++;
      if (!bus.mem_we_n) weLow++;
      if (isRead && n <= c && (bus.mem_ce_n || bus.mem_oe_n)) rdEnBad++;
      if (bus.rsp_valid) seen++;
      if (n == 1) begin
        checkOutput("ready_busy", bus.req_ready, 1'b0);
        if (!isRead) begin
          checkOutput("wr_bw", bus.mem_bw, (op == 2'b01));
          checkOutput("wr_ce", bus.mem_ce_n, 1'b0);
        end
      end
      if (vIdx < expC.size() && n == expC[vIdx] + 1) begin
        checkOutput("rsp_valid", bus.rsp_valid, 1'b1);
        checkOutput("rsp_rdata", bus.rsp_rdata, expD[vIdx]);
        checkOutput("rsp_last", bus.rsp_last, expL[vIdx]);
        checkOutput("rsp_err", bus.rsp_err, 1'b0);
        vIdx++;
      end
      if (aIdx < expC.size() && n == expC[aIdx]) begin
        checkOutput("mem_addr", bus.mem_addr, expA[aIdx]);
        aIdx++;
      end
      bus.mem_hold = (n - 1 < sched.size()) ? sched[n-1] : 1'b0;
    end

    checkOutput("ready_back", bus.req_ready, 1'b1);
    checkOutput("rsp_count", seen, nWords);
    checkOutput("oe_we_overlap", overlap, 0);
    if (isRead) begin
      checkOutput("rd_enables", rdEnBad, 0);
      model_rdata = expD[nWords-1];
    end else begin
      checkOutput("we_pulse", weLow, 1);
      refWrite(op, addr, wdata);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int seen;
    logic [31:0] v;
    logic [1:0] rop;
    reset = 1'b1;
    load_en = 1'b0; load_idx = '0; load_val = '0;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_hold = 1'b0;
    model_rdata = '0;

    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      v = (i == 0) ? 32'h1122_3344 : $urandom;
      load_en = 1'b1; load_idx = 6'(i); load_val = v;
      ref_mem[i] = v;
    end
    @(negedge clk);
    load_en = 1'b0;

    checkOutput("rst_ready", bus.req_ready, 1'b1);
    checkOutput("rst_valid", bus.rsp_valid, 1'b0);
    checkOutput("rst_last", bus.rsp_last, 1'b0);
    checkOutput("rst_err", bus.rsp_err, 1'b0);
    checkOutput("rst_rdata", bus.rsp_rdata, 32'h0);
    checkOutput("rst_enables", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n, bus.mem_bw}, 4'hF);
    checkOutput("rst_addr", bus.mem_addr, 32'h0);
    reset = 1'b0;

    applyStimulus(2'b00, 32'h1001_0002, 32'h0, 0);
    applyStimulus(2'b00, 32'h1001_0002, 32'h0, 3);
    applyStimulus(2'b01, 32'h1001_0008, 32'hDEAD_BEEF, 0);
    applyStimulus(2'b00, 32'h1001_0008, 32'h0, 0);
    applyStimulus(2'b01, 32'h1001_0004, 32'h0000_0000, 0);
    applyStimulus(2'b10, 32'h1001_0006, 32'h1234_56A5, 0);
    applyStimulus(2'b00, 32'h1001_0004, 32'h0, 0);
    applyStimulus(2'b11, 32'h1001_0014, 32'h0, 0);
    applyStimulus(2'b11, 32'h1001_0014, 32'h0, -1);

    // Reset in the middle of a line fill, right after the second word is delivered.
    waitReady();
    bus.req_valid = 1'b1; bus.req_op = 2'b11; bus.req_addr = BASE + 32'h34; bus.mem_hold = 1'b0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("fill_w1_valid", bus.rsp_valid, 1'b1);
    checkOutput("fill_w1_data", bus.rsp_rdata, refRead(BASE + 32'h34));
    reset = 1'b1;
    #1;
    checkOutput("midrst_enables", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}, 3'b111);
    checkOutput("midrst_ready", bus.req_ready, 1'b1);
    checkOutput("midrst_valid", bus.rsp_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_rdata = '0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    checkOutput("post_rst_valids", seen, 0);
    checkOutput("post_rst_rdata", bus.rsp_rdata, 32'h0);

    for (int t = 0; t < 40; t++) begin
      rop = 2'($urandom_range(0, 3));
      applyStimulus(rop, BASE + 32'($urandom_range(0, 255)), $urandom, -1);
    end

`ifdef HOLD_TIMEOUT_EN
    waitReady();
    bus.req_valid = 1'b1; bus.req_op = 2'b11; bus.req_addr = BASE + 32'h40; bus.mem_hold = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    seen = 0;
    for (int n = 1; n <= TMO + 3; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
      if (n == TMO + 1) begin
        checkOutput("tmo_valid", bus.rsp_valid, 1'b1);
        checkOutput("tmo_err", bus.rsp_err, 1'b1);
        checkOutput("tmo_last", bus.rsp_last, 1'b1);
        checkOutput("tmo_rdata", bus.rsp_rdata, 32'h0);
      end
    end
    checkOutput("tmo_count", seen, 1);
    checkOutput("tmo_ready", bus.req_ready, 1'b1);
    bus.mem_hold = 1'b0;
    model_rdata = '0;
    applyStimulus(2'b00, BASE + 32'h10, 32'h0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
